// File: rtl/mu0_reg_stack.sv
// mu0_reg_stack: WIDTH x DEPTH LIFO with push/pop, occupancy flags and sticky error.
// Define MU0_STACK_WRAP_EN for a circular store where a push on a full stack drops the oldest entry.
module mu0_reg_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Push,
  input  logic             Pop,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Empty,
  output logic             Full,
  output logic [CW-1:0]    Count,
  output logic             Err,
  input  logic             ErrClr
);

  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_OVERFLOW,
    OP_UNDERFLOW,
    OP_WRAP_PUSH
  } op_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic [AW-1:0]    top_idx, push_idx, wr_idx;
  logic             wr_en;
  logic             empty, full;
  op_e              op;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

`ifdef MU0_STACK_WRAP_EN
  logic [AW-1:0] bottom_q, bottom_d;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  // Sum of two values below DEPTH folds back into range with one subtraction.
  function automatic logic [AW-1:0] ring_idx(input logic [CW:0] s);
    logic [CW:0] r;
    r = (s >= {1'b0, DEPTH_C}) ? s - {1'b0, DEPTH_C} : s;
    return r[AW-1:0];
  endfunction

  assign top_idx  = ring_idx((CW+1)'(bottom_q) + (CW+1)'(count_q) - (CW+1)'(1));
  assign push_idx = ring_idx((CW+1)'(bottom_q) + (CW+1)'(count_q));
`else
  logic [CW-1:0] count_m1;

  assign count_m1 = count_q - CW'(1);
  assign top_idx  = count_m1[AW-1:0];
  assign push_idx = count_q[AW-1:0];
`endif

  always_comb begin
    op = OP_HOLD;
    unique case ({Push, Pop})
      2'b10: begin
        if (!full) begin
          op = OP_PUSH;
        end else begin
`ifdef MU0_STACK_WRAP_EN
          op = OP_WRAP_PUSH;
`else
          op = OP_OVERFLOW;
`endif
        end
      end
      2'b01:   op = empty ? OP_UNDERFLOW : OP_POP;
      2'b11:   op = empty ? OP_PUSH : OP_REPLACE;
      default: op = OP_HOLD;
    endcase
  end

  always_comb begin
    count_d = count_q;
    err_d   = ErrClr ? 1'b0 : err_q;
    wr_en   = 1'b0;
    wr_idx  = push_idx;
`ifdef MU0_STACK_WRAP_EN
    bottom_d = bottom_q;
`endif
    unique case (op)
      OP_PUSH: begin
        wr_en   = 1'b1;
        count_d = count_q + CW'(1);
      end
      OP_POP:       count_d = count_q - CW'(1);
      OP_REPLACE: begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end
      OP_OVERFLOW:  err_d = 1'b1;
      OP_UNDERFLOW: err_d = 1'b1;
      OP_WRAP_PUSH: begin
        wr_en = 1'b1;
`ifdef MU0_STACK_WRAP_EN
        bottom_d = (bottom_q == LAST_IDX) ? '0 : bottom_q + AW'(1);
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

`ifdef MU0_STACK_WRAP_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bottom_q <= '0;
    end else begin
      bottom_q <= bottom_d;
    end
  end
`endif

  // Storage is deliberately left uncleared by reset; Reset only blocks the write.
  always_ff @(posedge Clk) begin
    if (wr_en && !Reset) begin
      mem_q[wr_idx] <= D;
    end
  end

  assign Q     = empty ? '0 : mem_q[top_idx];
  assign Empty = empty;
  assign Full  = full;
  assign Count = count_q;
  assign Err   = err_q;

endmodule
